// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Data requests win arbitration; fetches can be squashed while in flight.
// A wedged memory is abandoned after TIMEOUT cycles.
//
// state  | meaning
// IDLE   | no access on the bus, arbitrating between d_req and if_req
// IFETCH | fetch access on the bus, waiting for mem_ready
// DATA   | load/store access on the bus, waiting for mem_ready
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_op,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [7:0]  TMO_MAX = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              drop_q, drop_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;

    logic [31:0]       if_rdata_d, d_rdata_d, mem_wdata_d;
    logic              if_valid_d, d_valid_d, d_err_d;
    logic              mem_req_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [3:0]        mem_be_d;

    logic [1:0]        d_off;
    logic              d_legal;
    logic [3:0]        d_be;
    logic [31:0]       d_wrep;
    logic [31:0]       ld_shift;
    logic [31:0]       ld_ext;
    logic              drop_now;

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    // Size decode of the pending data request: legality, byte enables, store lanes.
    always_comb begin
        d_off   = d_addr[1:0];
        d_legal = 1'b0;
        d_be    = 4'b0000;
        d_wrep  = d_wdata;
        case (d_op)
            3'b000, 3'b100: begin
                d_legal = 1'b1;
                d_be    = 4'b0001 << d_off;
                d_wrep  = {4{d_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                d_legal = ~d_off[0];
                d_be    = 4'b0011 << d_off;
                d_wrep  = {2{d_wdata[15:0]}};
            end
            3'b010: begin
                d_legal = (d_off == 2'b00);
                d_be    = 4'b1111;
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Load lane select and extension, using the size/offset captured at grant.
    always_comb begin
        ld_shift = mem_rdata >> {off_q, 3'b000};
        case (op_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        drop_d      = drop_q;
        op_d        = op_q;
        off_d       = off_q;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        d_err_d     = 1'b0;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;
        drop_now    = drop_q | if_kill;

        case (state_q)
            IDLE: begin
                // A requester still holds its req during its own valid pulse;
                // masking with the valid keeps it from being granted twice.
                if (d_req && !d_valid) begin
                    if (!d_legal) begin
                        d_valid_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'h0;
                    end else begin
                        state_d     = DATA;
                        tmo_d       = 8'h0;
                        op_d        = d_op;
                        off_d       = d_off;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = d_be;
                        mem_wdata_d = d_we ? d_wrep : 32'h0;
                    end
                end else if (if_req && !if_valid && !if_kill) begin
                    state_d     = IFETCH;
                    tmo_d       = 8'h0;
                    drop_d      = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = {if_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = 4'b1111;
                    mem_wdata_d = 32'h0;
                end
            end

            IFETCH: begin
                if (mem_ready || tmo_q == TMO_MAX) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                    if (!drop_now) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_ready ? mem_rdata : NOP;
                    end
                end else begin
                    tmo_d  = tmo_q + 8'h1;
                    drop_d = drop_now;
                end
            end

            DATA: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    d_rdata_d = mem_we ? 32'h0 : ld_ext;
                end else if (tmo_q == TMO_MAX) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_valid_d = 1'b1;
                    d_err_d   = 1'b1;
                    d_rdata_d = 32'h0;
                end else begin
                    tmo_d = tmo_q + 8'h1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_q     <= 8'h0;
            drop_q    <= 1'b0;
            op_q      <= 3'b000;
            off_q     <= 2'b00;
            if_rdata  <= 32'h0;
            if_valid  <= 1'b0;
            d_rdata   <= 32'h0;
            d_valid   <= 1'b0;
            d_err     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            drop_q    <= drop_d;
            op_q      <= op_d;
            off_q     <= off_d;
            if_rdata  <= if_rdata_d;
            if_valid  <= if_valid_d;
            d_rdata   <= d_rdata_d;
            d_valid   <= d_valid_d;
            d_err     <= d_err_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one linear sequence of steps,
// each checked against hand-computed values one time unit after the edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_op;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, if_stall, d_valid, d_err, d_stall, mem_req, mem_we;
    logic [3:0]  mem_be;

    int vectors     = 0;
    int miscompares = 0;
    int hi_cnt;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_op(d_op), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic data_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata);
        d_req = 1'b1; d_we = we; d_op = op; d_addr = addr; d_wdata = wdata;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 0; if_kill = 0; if_addr = 0;
        d_req = 0; d_we = 0; d_op = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_valids", {29'b0, if_valid, d_valid, d_err}, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // fetch only, minimum latency
        if_req = 1; if_addr = 32'h100; #1;
        chk("f_stall_n", {31'b0, if_stall}, 32'd1);
        tick();
        chk("f_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_be_we", {27'b0, mem_we, mem_be}, 32'h0F);
        chk("f_stall_n1", {31'b0, if_stall}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h0050_0093;
        tick();
        chk("f_valid", {31'b0, if_valid}, 32'd1);
        chk("f_rdata", if_rdata, 32'h0050_0093);
        chk("f_stall_n2", {31'b0, if_stall}, 32'd0);
        chk("f_req_drop", {31'b0, mem_req}, 32'd0);
        mem_ready = 0; if_req = 0;
        tick();
        chk("f_valid_pulse", {31'b0, if_valid}, 32'd0);

        // simultaneous fetch and LW: data first, fetch granted in d_valid cycle
        if_req = 1; if_addr = 32'h104;
        data_req(0, 3'b010, 32'h200, 32'h0);
        tick();
        chk("s_mem_addr_d", mem_addr, 32'h200);
        chk("s_mem_req", {31'b0, mem_req}, 32'd1);
        mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("s_d_valid", {30'b0, d_valid, d_err}, 32'd2);
        chk("s_d_rdata", d_rdata, 32'hCAFE_F00D);
        chk("s_if_stall", {31'b0, if_stall}, 32'd1);
        d_req = 0; mem_ready = 0;
        tick();
        chk("s_f_grant", {31'b0, mem_req}, 32'd1);
        chk("s_f_addr", mem_addr, 32'h104);
        chk("s_if_stall2", {31'b0, if_stall}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        tick();
        chk("s_if_valid", {31'b0, if_valid}, 32'd1);
        chk("s_if_rdata", if_rdata, 32'h1111_2222);
        if_req = 0; mem_ready = 0;
        tick();

        // LB at 0x203
        data_req(0, 3'b000, 32'h203, 32'h0);
        tick();
        chk("lb_be", {28'b0, mem_be}, 32'b1000);
        chk("lb_addr", mem_addr, 32'h200);
        mem_ready = 1; mem_rdata = 32'h80FF_7F01;
        tick();
        chk("lb_rdata", d_rdata, 32'hFFFF_FF80);
        d_req = 0; mem_ready = 0;
        tick();

        // LBU at 0x203
        data_req(0, 3'b100, 32'h203, 32'h0);
        tick();
        mem_ready = 1;
        tick();
        chk("lbu_rdata", d_rdata, 32'h0000_0080);
        d_req = 0; mem_ready = 0;
        tick();

        // LH at 0x202 (sign bit set)
        data_req(0, 3'b001, 32'h202, 32'h0);
        tick();
        mem_ready = 1;
        tick();
        chk("lh_rdata", d_rdata, 32'hFFFF_80FF);
        d_req = 0; mem_ready = 0;
        tick();

        // misaligned SW: no bus access, error pulse one cycle later
        data_req(1, 3'b010, 32'h201, 32'hAAAA_5555);
        tick();
        chk("sw_mis_noreq", {31'b0, mem_req}, 32'd0);
        chk("sw_mis_err", {30'b0, d_valid, d_err}, 32'd3);
        chk("sw_mis_rdata", d_rdata, 32'd0);
        d_req = 0;
        tick();
        chk("sw_mis_pulse", {30'b0, d_valid, d_err}, 32'd0);

        // illegal op 011
        data_req(0, 3'b011, 32'h200, 32'h0);
        tick();
        chk("op011_noreq", {31'b0, mem_req}, 32'd0);
        chk("op011_err", {30'b0, d_valid, d_err}, 32'd3);
        d_req = 0;
        tick();

        // SH at 0x202
        data_req(1, 3'b001, 32'h202, 32'h0000_1234);
        tick();
        chk("sh_be", {28'b0, mem_be}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        chk("sh_we", {31'b0, mem_we}, 32'd1);
        mem_ready = 1;
        tick();
        chk("sh_done", {30'b0, d_valid, d_err}, 32'd2);
        d_req = 0; mem_ready = 0;
        tick();

        // SB at 0x201
        data_req(1, 3'b000, 32'h201, 32'hFFFF_FFA5);
        tick();
        chk("sb_be", {28'b0, mem_be}, 32'b0010);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        mem_ready = 1;
        tick();
        d_req = 0; mem_ready = 0;
        tick();

        // killed fetch still completes on the bus but never returns
        if_req = 1; if_addr = 32'h180;
        tick();
        chk("k_mem_req", {31'b0, mem_req}, 32'd1);
        if_kill = 1;
        tick();
        if_kill = 0; if_req = 0;
        chk("k_held", {31'b0, mem_req}, 32'd1);
        tick();
        chk("k_held2", {31'b0, mem_req}, 32'd1);
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("k_drop_req", {31'b0, mem_req}, 32'd0);
        chk("k_no_valid", {31'b0, if_valid}, 32'd0);
        mem_ready = 0;
        if_req = 1; if_addr = 32'h300;
        tick();
        chk("k_regrant", {31'b0, mem_req}, 32'd1);
        chk("k_regrant_addr", mem_addr, 32'h300);
        mem_ready = 1; mem_rdata = 32'h0000_0113;
        tick();
        chk("k_new_valid", {31'b0, if_valid}, 32'd1);
        chk("k_new_rdata", if_rdata, 32'h0000_0113);
        if_req = 0; mem_ready = 0;
        tick();

        // if_kill in IDLE blocks the grant for that cycle only
        if_req = 1; if_addr = 32'h400; if_kill = 1;
        tick();
        chk("ik_blocked", {31'b0, mem_req}, 32'd0);
        if_kill = 0;
        tick();
        chk("ik_granted", mem_addr, 32'h400);
        chk("ik_req", {31'b0, mem_req}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h0000_0033;
        tick();
        chk("ik_valid", {31'b0, if_valid}, 32'd1);
        if_req = 0; mem_ready = 0;
        tick();

        // data timeout: mem_req held exactly 64 cycles
        data_req(0, 3'b010, 32'h240, 32'h0);
        tick();
        chk("to_d_stall", {31'b0, d_stall}, 32'd1);
        hi_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_req) hi_cnt++;
            tick();
        end
        chk("to_d_cycles", hi_cnt, 32'd64);
        chk("to_d_drop", {31'b0, mem_req}, 32'd0);
        chk("to_d_err", {30'b0, d_valid, d_err}, 32'd3);
        d_req = 0;
        tick();

        // fetch timeout returns a NOP
        if_req = 1; if_addr = 32'h500;
        tick();
        hi_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem_req) hi_cnt++;
            tick();
        end
        chk("to_f_cycles", hi_cnt, 32'd64);
        chk("to_f_valid", {31'b0, if_valid}, 32'd1);
        chk("to_f_nop", if_rdata, 32'h0000_0013);
        if_req = 0;
        tick();

        // reset mid-access drops mem_req at once and discards the response
        data_req(0, 3'b010, 32'h260, 32'h0);
        tick();
        chk("r_mem_req", {31'b0, mem_req}, 32'd1);
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        rst = 1; #1;
        chk("r_immediate", {31'b0, mem_req}, 32'd0);
        tick();
        chk("r_no_valid", {31'b0, d_valid}, 32'd0);
        mem_ready = 0;
        rst = 0;
        tick();
        chk("r_fresh_grant", {31'b0, mem_req}, 32'd1);
        chk("r_fresh_addr", mem_addr, 32'h260);
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        tick();
        chk("r_fresh_valid", {30'b0, d_valid, d_err}, 32'd2);
        chk("r_fresh_rdata", d_rdata, 32'h1234_5678);
        d_req = 0; mem_ready = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
